dither_dequant: RTL and testbench
=================================

# dither_dequant

Reconstruction-side companion to the stream rounder: accepts signed samples whose low NBITS were removed by round-to-nearest quantization and re-expands them to full DIN precision. The zeroed LSBs are replaced with uniform pseudo-random dither centred on the quantization cell, with saturation at the negative limit. It sits on a valid/ready stream between a quantized-data source and a full-precision consumer, with one registered pipeline stage.

## Interface
- NBITS, 4: number of quantized LSBs to reconstruct; 1 <= NBITS <= 16, NBITS < DIN
- DIN, 16: sample width, two's complement signed
- SEED, 16'hACE1: LFSR reset value; 0 is illegal and is replaced by 16'hACE1
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- din_ready  output  1  block can accept din this cycle
- din_valid  input  1  din_data is valid
- din_data  input  DIN  quantized sample; bits [NBITS-1:0] ignored
- dout_ready  input  1  downstream accepts dout this cycle
- dout_valid  output  1  dout_data is valid
- dout_data  output  DIN  reconstructed sample

## Operation
- Dither source: 16-bit Galois LFSR, right-shifting, tap mask 16'hB400 (x^16+x^14+x^13+x^11+1, maximal length).
- next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
- u = lfsr[NBITS-1:0] sampled before the advance; LFSR advances exactly once per accepted input (din_valid && din_ready), never otherwise.
- Let q = {din_data[DIN-1:NBITS], NBITS'b0}, signed DIN bits.
- r = q + u - 2^(NBITS-1), computed in DIN+1 signed bits.
- If r < -2^(DIN-1): dout_data = 2^(DIN-1) pattern (most negative, e.g. 16'h8000). Else dout_data = r[DIN-1:0].
- Positive overflow is impossible (max offset is 2^(NBITS-1)-1); no upper clamp is required.
- Output register: a single data/valid stage.
- din_ready = !dout_valid || dout_ready (combinational).
- On accept: dout_data <= result, dout_valid <= 1.
- On dout_valid && dout_ready with no accept: dout_valid <= 0.

## Timing
- Reset: dout_valid = 0, dout_data = 0, lfsr = SEED. din_ready reads 1 while rst is asserted and after release.
- Latency is 1 cycle from accept to dout_valid. Throughput is 1 sample/cycle under continuous dout_ready.
- Backpressure: while dout_valid && !dout_ready, dout_data is held stable, din_ready = 0, and the LFSR is frozen.
- Simultaneous pop and push (dout_valid && dout_ready && din_valid): the new sample is loaded in the same cycle with no bubble.
- The dither sequence depends only on the accept count, not on cycle count or stall pattern.
- Reset mid-operation: the in-flight sample is discarded, dout_valid drops asynchronously, and the LFSR is reseeded. The first post-reset accept uses u from SEED.
- din_data content is irrelevant when din_valid = 0. No state changes.

## Test plan
- Basic sequence, DIN=16, NBITS=4, SEED=16'hACE1: three accepts of 16'h0120 with dout_ready=1 -> dout_data 16'h0119, 16'h0118, 16'h0120 (u = 1, 0, 8), each one cycle after its accept.
- Ignored LSBs: repeat the basic sequence after reset with din_data = 16'h012F -> identical outputs 16'h0119, 16'h0118, 16'h0120.
- Negative saturation: after reset, first accept 16'h8000 (u=1) -> dout_data 16'h8000, not 16'h7FF9. Second accept 16'h8010 (u=0) -> 16'h8008.
- Backpressure: hold dout_ready=0 for 5 cycles after the first accept.
  - dout_data stays 16'h0119 and din_ready stays 0.
  - On release, the second sample still gets u=0 -> 16'h0118.
- Full-rate streaming: 1000 random inputs with dout_ready toggling randomly.
  - Every output matches the model (LFSR indexed by accept count).
  - No drops or duplicates.
  - 1 sample/cycle when dout_ready is held high.
- Reset mid-stream: assert rst while dout_valid=1 -> dout_valid falls immediately. After release, first accept of 16'h0120 -> 16'h0119.

Source files
------------

// File: rtl/dither_dequant.sv
// dither_dequant: re-expands round-to-nearest quantized samples to full precision,
// filling the dropped LSBs with centred LFSR dither and clamping at the negative limit.
module dither_dequant #(
  parameter int NBITS = 4,
  parameter int DIN = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  output logic           din_ready,
  input  logic           din_valid,
  input  logic [DIN-1:0] din_data,
  input  logic           dout_ready,
  output logic           dout_valid,
  output logic [DIN-1:0] dout_data
);
  localparam logic [15:0] SEED_I = (SEED == 16'h0) ? 16'hACE1 : SEED;
  logic [15:0] r_lfsr;
  logic r_valid;
  logic [DIN-1:0] r_data;
  logic w_acc;
  logic w_sat;
  logic w_unused;
  logic [DIN:0] w_q;
  logic [DIN:0] w_r;
  assign din_ready = !r_valid || dout_ready;
  assign w_acc = din_valid && din_ready;
  assign w_unused = ^din_data[NBITS-1:0];
  // one extra bit of headroom so the negative underflow is visible before clamping
  assign w_q = {din_data[DIN-1], din_data[DIN-1:NBITS], {NBITS{1'b0}}};
  assign w_r = w_q + (DIN+1)'(r_lfsr[NBITS-1:0]) - ((DIN+1)'(1) << (NBITS-1));
  assign w_sat = w_r[DIN] & ~w_r[DIN-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED_I;
      r_valid <= 1'b0;
      r_data <= '0;
    end else if (w_acc) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_data <= w_sat ? {1'b1, {(DIN-1){1'b0}}} : w_r[DIN-1:0];
      r_valid <= 1'b1;
    end else if (dout_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign dout_valid = r_valid;
  assign dout_data = r_data;
endmodule

// File: tb/tb_dither_dequant.sv
// tb_dither_dequant: randomized and directed checks of dither_dequant against a reference model.
module tb_dither_dequant;
  localparam int DIN = 16;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst;
  logic din_ready, din_valid, dout_ready, dout_valid;
  logic [DIN-1:0] din_data, dout_data;
  int n_tests = 0;
  int n_fail = 0;
  int acc;
  logic [15:0] useq [0:4095];
  logic [15:0] expq [$];
  logic held;
  logic [15:0] held_d;

  dither_dequant #(.NBITS(NB), .DIN(DIN), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .din_ready(din_ready), .din_valid(din_valid), .din_data(din_data),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input int k);
    int s, q, r;
    s = int'($signed(d));
    q = (s >>> NB) * (1 << NB);
    r = q + int'(useq[k] % (1 << NB)) - (1 << (NB - 1));
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic tick(input logic v, input logic [15:0] d, input logic rdy);
    din_valid = v;
    din_data = d;
    dout_ready = rdy;
    #1;
    if (held) check("hold_data", 32'(dout_data), 32'(held_d));
    if (dout_valid && !dout_ready) check("bp_ready", 32'(din_ready), 0);
    if (dout_ready) check("rdy", 32'(din_ready), 1);
    if (dout_valid && dout_ready) begin
      if (expq.size() == 0) check("spurious", 1, 0);
      else check("out", 32'(dout_data), 32'(expq.pop_front()));
    end
    if (din_valid && din_ready) begin
      expq.push_back(model(din_data, acc));
      acc++;
    end
    held = dout_valid && !dout_ready;
    held_d = dout_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    din_data = '0;
    dout_ready = 1'b0;
    #1;
    check("rst_valid", 32'(dout_valid), 0);
    repeat (2) @(negedge clk);
    check("rst_data", 32'(dout_data), 0);
    check("rst_ready", 32'(din_ready), 1);
    rst = 1'b0;
    expq.delete();
    acc = 0;
    held = 1'b0;
  endtask

  initial begin
    logic [15:0] l;
    int cyc;
    l = 16'hACE1;
    for (int i = 0; i < 4096; i++) begin
      useq[i] = l;
      l = (l >> 1) ^ ((l % 2 == 1) ? 16'hB400 : 16'h0000);
    end
    do_reset();
    tick(1'b1, 16'h0120, 1'b1);
    check("basic0", 32'(dout_data), 32'h0119);
    check("basic0_v", 32'(dout_valid), 1);
    tick(1'b1, 16'h0120, 1'b1);
    check("basic1", 32'(dout_data), 32'h0118);
    tick(1'b1, 16'h0120, 1'b1);
    check("basic2", 32'(dout_data), 32'h0120);
    tick(1'b0, 16'h0000, 1'b1);
    check("basic_idle", 32'(dout_valid), 0);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 16'h012F, 1'b1);
    check("lsb2", 32'(dout_data), 32'h0120);
    tick(1'b0, 16'h0000, 1'b1);
    do_reset();
    tick(1'b1, 16'h8000, 1'b1);
    check("sat0", 32'(dout_data), 32'h8000);
    tick(1'b1, 16'h8010, 1'b1);
    check("sat1", 32'(dout_data), 32'h8008);
    tick(1'b0, 16'h0000, 1'b1);
    do_reset();
    tick(1'b1, 16'h0120, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 16'h0120, 1'b0);
    check("bp_data", 32'(dout_data), 32'h0119);
    tick(1'b1, 16'h0120, 1'b1);
    check("bp_next", 32'(dout_data), 32'h0118);
    tick(1'b1, 16'h0120, 1'b0);
    check("mid_pre_v", 32'(dout_valid), 1);
    do_reset();
    tick(1'b1, 16'h0120, 1'b1);
    check("mid_post", 32'(dout_data), 32'h0119);
    tick(1'b0, 16'h0000, 1'b1);
    do_reset();
    cyc = 0;
    while (acc < 1000 && cyc < 10000) begin
      tick($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? (16'h8000 | 16'($urandom_range(0, 31))) : 16'($urandom),
           1'($urandom_range(0, 1)));
      cyc++;
    end
    check("stream_count", 32'(acc >= 1000), 1);
    for (int i = 0; i < 50; i++) tick(1'b1, 16'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000, 1'b1);
    check("drain", 32'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
